// File: rtl/bp_pkg.sv
// bp_pkg: shared branch-prediction types for the predictor and the resolve queue
package bp_pkg;
    localparam int PC_W = 32;
    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic            pred;
        logic [PC_W-1:0] alt_pc;
    } brq_entry_t;
    typedef enum logic [1:0] {NOT_TAKEN, NOT_TAKEN2, TAKEN, TAKEN2} bp_state_e;
endpackage

// File: rtl/branch_resolve_queue_if.sv
// branch_resolve_queue_if: fetch/execute/predictor bundle around the resolve queue
interface branch_resolve_queue_if #(
    parameter int PC_W  = bp_pkg::PC_W,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);
    logic            alloc_valid;
    logic [PC_W-1:0] alloc_pc;
    logic            alloc_pred;
    logic [PC_W-1:0] alloc_alt_pc;
    logic            alloc_ready;
    logic            resolve_valid;
    logic [PC_W-1:0] resolve_pc;
    logic            resolve_taken;
    logic            upd_valid;
    logic [PC_W-1:0] upd_pc;
    logic            upd_taken;
    logic            commit;
    logic            rollback;
    logic [PC_W-1:0] rollback_pc;
    logic            resolve_err;
    logic [CW-1:0]   count;
    modport master (
        output alloc_valid, alloc_pc, alloc_pred, alloc_alt_pc, resolve_valid, resolve_pc, resolve_taken,
        input  alloc_ready, upd_valid, upd_pc, upd_taken, commit, rollback, rollback_pc, resolve_err, count
    );
    modport slave (
        input  alloc_valid, alloc_pc, alloc_pred, alloc_alt_pc, resolve_valid, resolve_pc, resolve_taken,
        output alloc_ready, upd_valid, upd_pc, upd_taken, commit, rollback, rollback_pc, resolve_err, count
    );
endinterface

// File: rtl/brq_fifo.sv
// brq_fifo: circular entry store with push/pop and a whole-queue flush
module brq_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  brq_entry_t    wr_entry_i,
    output brq_entry_t    head_entry_o,
    output logic [CW-1:0] count_o
);
    localparam int PW = $clog2(DEPTH);
    brq_entry_t    mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    // pointer/occupancy next state; flush beats any push or pop
    always_comb begin
        head_d  = flush_i ? '0 : pop_i ? head_q + 1'b1 : head_q;
        tail_d  = flush_i ? '0 : push_i ? tail_q + 1'b1 : tail_q;
        count_d = flush_i ? '0 : count_q + CW'(push_i) - CW'(pop_i);
    end
    // pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
    // entry storage, left uncleared on reset
    always_ff @(posedge clk) begin
        if (push_i) mem_q[tail_q] <= wr_entry_i;
    end
    assign head_entry_o = mem_q[head_q];
    assign count_o      = count_q;
endmodule

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: holds predicted branches until execute resolves them, trains and redirects
module branch_resolve_queue
    import bp_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = bp_pkg::PC_W
) (
    input logic clk,
    input logic rst,
    branch_resolve_queue_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    brq_entry_t      head, wr_entry;
    logic [CW-1:0]   count;
    logic            res_ok, mis, err, push, pop;
    logic            upd_valid_q, upd_valid_d, commit_q, commit_d, rollback_q, rollback_d;
    logic            err_q, err_d, upd_taken_q, upd_taken_d;
    logic [PC_W-1:0] upd_pc_q, upd_pc_d, rb_pc_q, rb_pc_d;
    brq_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .pop_i        (pop),
        .flush_i      (mis),
        .wr_entry_i   (wr_entry),
        .head_entry_o (head),
        .count_o      (count)
    );
    assign bus.alloc_ready = count != CW'(DEPTH);
    // resolve classification and response next state; a mispredict discards a same-cycle alloc
    always_comb begin
        wr_entry    = '{pc: bus.alloc_pc, pred: bus.alloc_pred, alt_pc: bus.alloc_alt_pc};
        res_ok      = bus.resolve_valid && count != '0 && bus.resolve_pc == head.pc;
        mis         = res_ok && bus.resolve_taken != head.pred;
        err         = bus.resolve_valid && !res_ok;
        push        = bus.alloc_valid && bus.alloc_ready && !mis;
        pop         = res_ok && !mis;
        upd_valid_d = res_ok;
        commit_d    = pop;
        rollback_d  = mis;
        err_d       = err;
        upd_pc_d    = res_ok ? head.pc : upd_pc_q;
        upd_taken_d = res_ok ? bus.resolve_taken : upd_taken_q;
        rb_pc_d     = mis ? head.alt_pc : rb_pc_q;
    end
    // registered responses; reset drops any pulse that was about to issue
    always_ff @(posedge clk) begin
        if (rst) begin
            upd_valid_q <= 1'b0;
            commit_q    <= 1'b0;
            rollback_q  <= 1'b0;
            err_q       <= 1'b0;
            upd_pc_q    <= '0;
            upd_taken_q <= 1'b0;
            rb_pc_q     <= '0;
        end else begin
            upd_valid_q <= upd_valid_d;
            commit_q    <= commit_d;
            rollback_q  <= rollback_d;
            err_q       <= err_d;
            upd_pc_q    <= upd_pc_d;
            upd_taken_q <= upd_taken_d;
            rb_pc_q     <= rb_pc_d;
        end
    end
    assign bus.upd_valid   = upd_valid_q;
    assign bus.upd_pc      = upd_pc_q;
    assign bus.upd_taken   = upd_taken_q;
    assign bus.commit      = commit_q;
    assign bus.rollback    = rollback_q;
    assign bus.rollback_pc = rb_pc_q;
    assign bus.resolve_err = err_q;
    assign bus.count       = count;
endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb_branch_resolve_queue: directed scoreboard bench for the branch resolve queue
module tb_branch_resolve_queue;
    localparam int DEPTH = 4;
    localparam int PC_W  = 32;
    typedef struct packed {
        logic [31:0] pc;
        logic        pred;
        logic [31:0] alt;
    } ent_t;
    typedef struct packed {
        logic        uv, cm, rb, er, ut, rdy;
        logic [31:0] up, rbp;
        logic [31:0] cnt;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          checks = 0;
    int          errors = 0;
    ent_t        mq[$];
    exp_t        exp_q[$];
    logic [31:0] m_up = '0, m_rb = '0;
    logic        m_ut = 1'b0;
    branch_resolve_queue_if #(.PC_W(PC_W), .DEPTH(DEPTH)) bus ();
    branch_resolve_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic step(input logic r, input logic av, input logic [31:0] apc, input logic ap,
                        input logic [31:0] aalt, input logic rv, input logic [31:0] rpc, input logic rt);
        exp_t e, g;
        logic rdy, mis;
        ent_t h;
        @(negedge clk);
        rst = r;
        bus.alloc_valid = av; bus.alloc_pc = apc; bus.alloc_pred = ap; bus.alloc_alt_pc = aalt;
        bus.resolve_valid = rv; bus.resolve_pc = rpc; bus.resolve_taken = rt;
        rdy = mq.size() != DEPTH;
        if (!r) chk("alloc_ready_pre", {31'b0, bus.alloc_ready}, {31'b0, rdy});
        e = '0;
        mis = 1'b0;
        if (r) begin
            mq.delete(); m_up = '0; m_ut = 1'b0; m_rb = '0;
        end else begin
            if (rv) begin
                if (mq.size() == 0 || mq[0].pc != rpc) e.er = 1'b1;
                else begin
                    h = mq[0];
                    e.uv = 1'b1; m_up = h.pc; m_ut = rt;
                    if (rt == h.pred) begin
                        e.cm = 1'b1;
                        void'(mq.pop_front());
                    end else begin
                        e.rb = 1'b1; m_rb = h.alt; mis = 1'b1;
                        mq.delete();
                    end
                end
            end
            if (av && rdy && !mis) mq.push_back('{apc, ap, aalt});
        end
        e.up = m_up; e.ut = m_ut; e.rbp = m_rb;
        e.cnt = mq.size();
        e.rdy = mq.size() != DEPTH;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        g = exp_q.pop_front();
        chk("count", 32'(bus.count), g.cnt);
        chk("alloc_ready", {31'b0, bus.alloc_ready}, {31'b0, g.rdy});
        chk("upd_valid", {31'b0, bus.upd_valid}, {31'b0, g.uv});
        chk("commit", {31'b0, bus.commit}, {31'b0, g.cm});
        chk("rollback", {31'b0, bus.rollback}, {31'b0, g.rb});
        chk("resolve_err", {31'b0, bus.resolve_err}, {31'b0, g.er});
        chk("upd_pc", bus.upd_pc, g.up);
        chk("upd_taken", {31'b0, bus.upd_taken}, {31'b0, g.ut});
        chk("rollback_pc", bus.rollback_pc, g.rbp);
    endtask
    task automatic idle();
        step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
    endtask
    task automatic alloc(input logic [31:0] pc, input logic p, input logic [31:0] alt);
        step(1'b0, 1'b1, pc, p, alt, 1'b0, '0, 1'b0);
    endtask
    task automatic resolve(input logic [31:0] pc, input logic t);
        step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1, pc, t);
    endtask
    task automatic both(input logic [31:0] apc, input logic p, input logic [31:0] alt,
                        input logic [31:0] rpc, input logic t);
        step(1'b0, 1'b1, apc, p, alt, 1'b1, rpc, t);
    endtask
    initial begin
        bus.alloc_valid = 1'b0; bus.alloc_pc = '0; bus.alloc_pred = 1'b0; bus.alloc_alt_pc = '0;
        bus.resolve_valid = 1'b0; bus.resolve_pc = '0; bus.resolve_taken = 1'b0;
        step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0);
        idle();
        alloc(32'h100, 1'b1, 32'h108);
        resolve(32'h100, 1'b1);
        alloc(32'h100, 1'b1, 32'h108);
        alloc(32'h200, 1'b0, 32'h240);
        resolve(32'h100, 1'b0);
        resolve(32'h200, 1'b0);
        alloc(32'h10, 1'b1, 32'h14);
        alloc(32'h20, 1'b0, 32'h60);
        alloc(32'h30, 1'b1, 32'h34);
        alloc(32'h40, 1'b0, 32'h80);
        alloc(32'h50, 1'b1, 32'h54);
        resolve(32'h10, 1'b1);
        resolve(32'h20, 1'b0);
        resolve(32'h30, 1'b1);
        resolve(32'h40, 1'b0);
        resolve(32'h50, 1'b1);
        resolve(32'h100, 1'b1);
        alloc(32'h100, 1'b1, 32'h108);
        resolve(32'h300, 1'b1);
        both(32'h400, 1'b1, 32'h404, 32'h100, 1'b0);
        resolve(32'h400, 1'b1);
        alloc(32'h500, 1'b0, 32'h540);
        both(32'h600, 1'b1, 32'h604, 32'h500, 1'b0);
        both(32'h700, 1'b0, 32'h740, 32'h9999, 1'b1);
        resolve(32'h600, 1'b1);
        resolve(32'h700, 1'b0);
        alloc(32'h1000, 1'b0, 32'h1040);
        for (int i = 1; i < 20; i++)
            both(32'h1000 + 32'(i * 4), 1'(i % 2), 32'h1040 + 32'(i * 4),
                 32'h1000 + 32'((i - 1) * 4), 1'((i - 1) % 2));
        resolve(32'h1000 + 32'(19 * 4), 1'b1);
        alloc(32'hA00, 1'b1, 32'hA04);
        alloc(32'hA10, 1'b0, 32'hA50);
        step(1'b1, 1'b1, 32'hA20, 1'b1, 32'hA24, 1'b1, 32'hA00, 1'b1);
        resolve(32'hA00, 1'b1);
        idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_resolve_queue.md
# branch_resolve_queue

Tracks every branch the predictor has steered fetch around until the execute stage resolves it. It sits directly downstream of the branch predictor:
- On each prediction, fetch allocates an entry holding branch PC, predicted direction and the alternate (not-chosen) target.
- On resolution, the head entry is checked, the predictor's 2-bit history table is trained, and fetch receives a commit or a rollback with the correct PC.

## Interface
- DEPTH, 4, in-flight branch capacity; power of two, ≥2
- PC_W, 32, PC width
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- alloc_valid  in  1  fetch issued a predicted branch this cycle
- alloc_pc  in  PC_W  PC of that branch
- alloc_pred  in  1  predicted direction (1 = taken)
- alloc_alt_pc  in  PC_W  target not chosen (notTaken PC if predicted taken, taken PC otherwise)
- alloc_ready  out  1  entry available; fetch must stall a branch while low
- resolve_valid  in  1  execute resolved the oldest in-flight branch
- resolve_pc  in  PC_W  PC of resolved branch (checked against head)
- resolve_taken  in  1  actual direction
- upd_valid  out  1  one-cycle train strobe to predictor
- upd_pc  out  PC_W  PC to train (predictor indexes [9:2])
- upd_taken  out  1  actual direction for training
- commit  out  1  one-cycle pulse: head prediction correct
- rollback  out  1  one-cycle pulse: mispredict, flush fetch
- rollback_pc  out  PC_W  correct fetch PC, valid with rollback
- resolve_err  out  1  one-cycle pulse: resolve with queue empty or PC mismatch
- count  out  clog2(DEPTH+1)  current occupancy

## Operation
- Circular FIFO:
  - head/tail pointers clog2(DEPTH) bits, wrap modulo DEPTH.
  - count tracks occupancy (0..DEPTH).
- alloc_ready = (count != DEPTH), combinational from state only. No same-cycle bypass when full, even if a resolve frees the head.
- Alloc accepted when alloc_valid && alloc_ready: write {alloc_pc, alloc_pred, alloc_alt_pc} at tail, tail+1. alloc_valid while full is ignored; there is no error.
- Resolve with count==0: resolve_err=1; nothing else changes.
- Resolve with resolve_pc != head.pc: resolve_err=1; entry left in place, no training.
- Resolve with PC match:
  - upd_valid=1, upd_pc=head.pc, upd_taken=resolve_taken.
  - Pop head.
  - If resolve_taken == head.pred: commit=1.
  - Otherwise: rollback=1, rollback_pc=head.alt_pc, and the whole queue is flushed (head=tail=0, count=0). All younger entries are wrong-path.
- Simultaneous alloc + correct resolve: both take effect; count unchanged.
- Simultaneous alloc + mispredict: flush wins and the alloc is discarded (wrong-path branch).
- Simultaneous alloc + resolve_err: the alloc proceeds normally.
- commit, rollback and resolve_err are mutually exclusive.

## Timing
- All outputs except alloc_ready are registered: responses appear the cycle after resolve_valid and last exactly one cycle.
- upd_pc, upd_taken and rollback_pc hold their last value when not strobed.
- Allocation is visible in count the cycle after acceptance. An entry allocated in cycle N may be resolved in cycle N+1 or later.
- After a mispredict in cycle N:
  - count=0 in cycle N+1.
  - alloc_ready=1 in cycle N+1.
  - Allocs in N+1 are accepted (correct path).
- Reset values:
  - Outputs: count=0, upd_valid=0, commit=0, rollback=0, resolve_err=0, upd_pc=0, upd_taken=0, rollback_pc=0, alloc_ready=1.
  - State: pointers 0. Entry storage need not be cleared.
- rst mid-operation discards all entries in the same edge, and pending pulses are not emitted.

## Structure
- Shared package bp_pkg holds:
  - PC_W default
  - brq_entry_t struct {pc, pred, alt_pc}
  - predictor state encodings (notTaken, notTaken2, taken, taken2) shared with the predictor
- One sub-module, brq_fifo: storage, pointers, count, with push/pop/flush inputs.
- The top level holds the compare/resolve logic and the output registers.

## Test plan
- Reset, then alloc pc=0x100, pred=1, alt=0x108; resolve pc=0x100, taken=1 -> next cycle commit=1, upd_valid=1, upd_pc=0x100, upd_taken=1, count=0.
- Alloc 0x100 (pred=1, alt=0x108) and 0x200 (pred=0, alt=0x240); resolve 0x100 taken=0 -> rollback=1, rollback_pc=0x108, upd_taken=0, count=0; entry 0x200 gone.
- Alloc 4 branches (DEPTH=4) -> alloc_ready=0; 5th alloc_valid ignored; resolve head correct -> alloc_ready=1 next cycle, count=3.
- Resolve with count=0, then resolve pc=0x300 while head=0x100 -> resolve_err pulses each time, no upd_valid, count unchanged.
- Same-cycle alloc 0x400 with mispredict of head -> count=0 next cycle, 0x400 not retained. Same-cycle alloc with correct resolve -> count unchanged.
- 20 alloc/resolve pairs wrapping pointers several times -> every upd_pc matches allocation order. Assert rst mid-run -> count=0 and no pulses.
